// File: rtl/stream_source.sv
// ---------------------------------------------------------------------------
// stream_source
// Programmable valid/ready data stream generator for block-level benches and
// on-chip loopback checks. Each job emits num_beats_i beats (or runs until
// stop_i when num_beats_i is 0), separated by gap_i idle cycles, with packet
// framing on last_o and one of four data patterns.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      start a job (sampled only while idle)
//   stop_i       graceful abort of the running job
//   mode_i       0 increment, 1 LFSR, 2 constant, 3 decrement
//   seed_i       first data value
//   gap_i        idle cycles between beats
//   num_beats_i  beats per job, 0 = unbounded
//   ready_i      sink ready
//   valid_o      data_o valid
//   data_o       stream data
//   last_o       final beat of a packet or of the job
//   busy_o       job in progress (any state other than idle)
//   done_o       one-cycle pulse on normal job completion
//   beat_cnt_o   accepted beats in the current or last job
// ---------------------------------------------------------------------------
module stream_source #(
    parameter int                 DATA_W    = 8,
    parameter int                 GAP_W     = 4,
    parameter int                 CNT_W     = 16,
    parameter int                 PKT_LEN   = 16,
    parameter logic [DATA_W-1:0]  LFSR_TAPS = 8'hB8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic [GAP_W-1:0]  gap_i,
    input  logic [CNT_W-1:0]  num_beats_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  beat_cnt_o
);

    localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_LEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_CONST = 2'd2;
    localparam logic [1:0] MODE_DEC   = 2'd3;

    // Even parity of a data word (LFSR feedback).
    function automatic logic parity(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction

    // Data value following cur in the given pattern.
    function automatic logic [DATA_W-1:0] next_data(input logic [1:0] mode,
                                                    input logic [DATA_W-1:0] cur);
        logic [DATA_W-1:0] res;
        case (mode)
            MODE_INC:   res = cur + DATA_W'(1);
            MODE_DEC:   res = cur - DATA_W'(1);
            MODE_LFSR:  res = {cur[DATA_W-2:0], parity(cur & LFSR_TAPS)};
            MODE_CONST: res = cur;
            default:    res = cur;
        endcase
        return res;
    endfunction

    logic [1:0]        state_r,     state_nxt_s;
    logic [1:0]        mode_r,      mode_nxt_s;
    logic [GAP_W-1:0]  gap_len_r,   gap_len_nxt_s;
    logic [CNT_W-1:0]  num_r,       num_nxt_s;
    logic [GAP_W-1:0]  gap_cnt_r,   gap_cnt_nxt_s;
    logic [DATA_W-1:0] data_r,      data_nxt_s;
    logic [CNT_W-1:0]  beat_r,      beat_nxt_s;
    logic [PKT_W-1:0]  pkt_r,       pkt_nxt_s;
    logic              stop_pend_r, stop_pend_nxt_s;
    logic              valid_r,     valid_nxt_s;
    logic              last_r,      last_nxt_s;
    logic              done_r,      done_nxt_s;
    logic              busy_r,      busy_nxt_s;
    logic              xfer_s;
    logic              stop_req_s;
    logic              final_beat_s;

    assign xfer_s       = valid_r & ready_i;
    // A stop seen at any point of a stalled beat is remembered until the beat goes.
    assign stop_req_s   = stop_pend_r | stop_i;
    assign final_beat_s = (num_r != {CNT_W{1'b0}}) && (beat_r == num_r - CNT_W'(1));

    // Next-state and next-output computation for the job sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        mode_nxt_s      = mode_r;
        gap_len_nxt_s   = gap_len_r;
        num_nxt_s       = num_r;
        gap_cnt_nxt_s   = gap_cnt_r;
        data_nxt_s      = data_r;
        beat_nxt_s      = beat_r;
        pkt_nxt_s       = pkt_r;
        stop_pend_nxt_s = stop_pend_r;

        case (state_r)
            ST_IDLE: begin
                stop_pend_nxt_s = 1'b0;
                if (start_i) begin
                    mode_nxt_s    = mode_i;
                    gap_len_nxt_s = gap_i;
                    num_nxt_s     = num_beats_i;
                    beat_nxt_s    = {CNT_W{1'b0}};
                    pkt_nxt_s     = {PKT_W{1'b0}};
                    // An all-zero LFSR state would lock up, so it starts at 1.
                    if ((mode_i == MODE_LFSR) && (seed_i == {DATA_W{1'b0}})) begin
                        data_nxt_s = DATA_W'(1);
                    end else begin
                        data_nxt_s = seed_i;
                    end
                    if (gap_i == {GAP_W{1'b0}}) begin
                        state_nxt_s = ST_SEND;
                    end else begin
                        state_nxt_s   = ST_GAP;
                        gap_cnt_nxt_s = gap_i - GAP_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (stop_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (gap_cnt_r == {GAP_W{1'b0}}) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r - GAP_W'(1);
                end
            end
            ST_SEND: begin
                stop_pend_nxt_s = stop_req_s;
                if (xfer_s) begin
                    beat_nxt_s = beat_r + CNT_W'(1);
                    pkt_nxt_s  = (pkt_r == PKT_LAST) ? {PKT_W{1'b0}} : pkt_r + PKT_W'(1);
                    data_nxt_s = next_data(mode_r, data_r);
                    if (stop_req_s) begin
                        state_nxt_s = ST_IDLE;
                    end else if (final_beat_s) begin
                        state_nxt_s = ST_DONE;
                    end else if (gap_len_r != {GAP_W{1'b0}}) begin
                        state_nxt_s   = ST_GAP;
                        gap_cnt_nxt_s = gap_len_r - GAP_W'(1);
                    end else begin
                        state_nxt_s = ST_SEND;
                    end
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        valid_nxt_s = (state_nxt_s == ST_SEND);
        done_nxt_s  = (state_nxt_s == ST_DONE);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
        last_nxt_s  = valid_nxt_s &&
                      ((pkt_nxt_s == PKT_LAST) ||
                       ((num_nxt_s != {CNT_W{1'b0}}) &&
                        (beat_nxt_s == num_nxt_s - CNT_W'(1))));
    end

    // State and registered outputs with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            mode_r      <= 2'd0;
            gap_len_r   <= {GAP_W{1'b0}};
            num_r       <= {CNT_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            beat_r      <= {CNT_W{1'b0}};
            pkt_r       <= {PKT_W{1'b0}};
            stop_pend_r <= 1'b0;
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mode_r      <= mode_nxt_s;
            gap_len_r   <= gap_len_nxt_s;
            num_r       <= num_nxt_s;
            gap_cnt_r   <= gap_cnt_nxt_s;
            data_r      <= data_nxt_s;
            beat_r      <= beat_nxt_s;
            pkt_r       <= pkt_nxt_s;
            stop_pend_r <= stop_pend_nxt_s;
            valid_r     <= valid_nxt_s;
            last_r      <= last_nxt_s;
            done_r      <= done_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign valid_o    = valid_r;
    assign data_o     = data_r;
    assign last_o     = last_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign beat_cnt_o = beat_r;

endmodule

// File: tb/tb_stream_source.sv
// ---------------------------------------------------------------------------
// tb_stream_source
// Self-checking bench for stream_source (default parameters). Each job is
// described by its configuration; the expected beat stream, the cycle in
// which each beat should appear and the completion behaviour are computed
// from those parameters with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_stream_source;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic        stop_i;
    logic [1:0]  mode_i;
    logic [7:0]  seed_i;
    logic [3:0]  gap_i;
    logic [15:0] num_beats_i;
    logic        ready_i;
    logic        valid_o;
    logic [7:0]  data_o;
    logic        last_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] beat_cnt_o;

    int n_assert;
    int n_fail;

    stream_source dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .mode_i      (mode_i),
        .seed_i      (seed_i),
        .gap_i       (gap_i),
        .num_beats_i (num_beats_i),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .beat_cnt_o  (beat_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected value of beat k (0-based) of a job.
    function automatic logic [7:0] model_data(input logic [1:0] m, input logic [7:0] seed,
                                              input int k);
        logic [7:0] d;
        case (m)
            2'd0:    return seed + 8'(k);
            2'd3:    return seed - 8'(k);
            2'd2:    return seed;
            default: begin
                d = (seed == 8'd0) ? 8'd1 : seed;
                for (int i = 0; i < k; i++) begin
                    d = {d[6:0], 1'(($countones(d & 8'hB8)) % 2)};
                end
                return d;
            end
        endcase
    endfunction

    // Runs one job. rdy_pct is the ready probability; stop_beat >= 0 raises
    // stop_i when that beat is first presented, stalls it 3 cycles, then accepts.
    task automatic run_job(input logic [1:0] m, input logic [7:0] seed, input logic [3:0] g,
                           input logic [15:0] n, input int rdy_pct, input int stop_beat);
        int  k;
        int  idx;
        int  next_valid;
        int  budget;
        int  stall;
        bit  stopping;
        bit  fin;
        bit  timed_out;
        logic exp_last;
        @(negedge clk_i);
        mode_i = m; seed_i = seed; gap_i = g; num_beats_i = n;
        start_i = 1'b1; ready_i = 1'b0; stop_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        k = 0; idx = 1; next_valid = 1 + int'(g); stall = 0;
        stopping = 1'b0; fin = 1'b0; timed_out = 1'b0;
        budget = 40 * (int'(n) + stop_beat + 8) * (int'(g) + 2);
        while (!fin) begin
            chk("valid", 32'(valid_o), 32'(idx >= next_valid));
            chk("busy", 32'(busy_o), 32'd1);
            chk("done_early", 32'(done_o), 32'd0);
            chk("beat_cnt", 32'(beat_cnt_o), 32'(k));
            if (valid_o) begin
                chk("data", 32'(data_o), 32'(model_data(m, seed, k)));
                exp_last = ((k % 16) == 15) || ((n != 16'd0) && (k == int'(n) - 1));
                chk("last", 32'(last_o), 32'(exp_last));
            end
            // Noise on the config/start inputs must have no effect mid-job.
            start_i     = ($urandom_range(0, 7) == 0);
            mode_i      = 2'($urandom);
            seed_i      = 8'($urandom);
            gap_i       = 4'($urandom);
            num_beats_i = 16'($urandom);
            if ((stop_beat >= 0) && (k == stop_beat) && valid_o && !stopping) begin
                stopping = 1'b1;
                stop_i   = 1'b1;
                stall    = 3;
            end
            if (stopping) begin
                if (stall > 0) begin
                    ready_i = 1'b0;
                    stall--;
                end else begin
                    ready_i = 1'b1;
                end
            end else begin
                ready_i = ($urandom_range(0, 99) < rdy_pct);
            end
            if (valid_o && ready_i) begin
                k++;
                next_valid = idx + 1 + int'(g);
                if (stopping || ((n != 16'd0) && (k == int'(n)))) fin = 1'b1;
            end
            idx++;
            if (idx > budget) begin
                n_assert++;
                n_fail++;
                $error("FAIL timeout beats=%0d required=%0d", k, n);
                fin = 1'b1;
                timed_out = 1'b1;
            end
            @(negedge clk_i);
        end
        start_i = 1'b0;
        ready_i = 1'b0;
        if (!timed_out) begin
            if (stopping) begin
                chk("stop_idle_busy", 32'(busy_o), 32'd0);
                chk("stop_valid", 32'(valid_o), 32'd0);
                chk("stop_no_done", 32'(done_o), 32'd0);
                chk("stop_beat_cnt", 32'(beat_cnt_o), 32'(k));
                stop_i = 1'b0;
            end else begin
                chk("done_pulse", 32'(done_o), 32'd1);
                chk("done_valid", 32'(valid_o), 32'd0);
                chk("done_busy", 32'(busy_o), 32'd1);
                chk("done_beat_cnt", 32'(beat_cnt_o), 32'(n));
                @(negedge clk_i);
                chk("done_once", 32'(done_o), 32'd0);
                chk("idle_busy", 32'(busy_o), 32'd0);
                chk("hold_beat_cnt", 32'(beat_cnt_o), 32'(n));
            end
        end
        stop_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_data"}, 32'(data_o), 32'd0);
        chk({tag, "_last"}, 32'(last_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_beat_cnt"}, 32'(beat_cnt_o), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        rst_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b0;
        mode_i = 2'd0; seed_i = 8'd0; gap_i = 4'd0; num_beats_i = 16'd0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Full-throughput increment with wrap, packet framing and job end.
        run_job(2'd0, 8'h01, 4'd0, 16'd256, 100, -1);
        // Gap of 4: one beat every five cycles, first at t+5.
        run_job(2'd0, 8'h00, 4'd4, 16'd8, 100, -1);
        // Backpressure on increment.
        run_job(2'd0, 8'h3C, 4'd0, 16'd40, 50, -1);
        // LFSR from 1, and zero seed behaving as 1.
        run_job(2'd1, 8'h01, 4'd0, 16'd20, 100, -1);
        run_job(2'd1, 8'h00, 4'd1, 16'd10, 70, -1);
        // Decrement through zero, constant pattern.
        run_job(2'd3, 8'h02, 4'd2, 16'd6, 60, -1);
        run_job(2'd2, 8'hA5, 4'd0, 16'd5, 60, -1);
        // Unbounded job ended by stop, and stop inside a finite job with gaps.
        run_job(2'd0, 8'hF0, 4'd0, 16'd0, 70, 20);
        run_job(2'd0, 8'h10, 4'd3, 16'd30, 100, 4);
        // Randomised jobs.
        for (int j = 0; j < 6; j++) begin
            run_job(2'($urandom), 8'($urandom), 4'($urandom_range(0, 3)),
                    16'($urandom_range(1, 40)), $urandom_range(30, 100), -1);
        end

        // stop_i during a gap returns to idle on the next cycle without done.
        @(negedge clk_i);
        mode_i = 2'd0; seed_i = 8'h20; gap_i = 4'd6; num_beats_i = 16'd10; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("gap_busy", 32'(busy_o), 32'd1);
        chk("gap_valid", 32'(valid_o), 32'd0);
        stop_i = 1'b1;
        @(negedge clk_i);
        stop_i = 1'b0;
        chk("gapstop_busy", 32'(busy_o), 32'd0);
        chk("gapstop_done", 32'(done_o), 32'd0);
        chk("gapstop_beat_cnt", 32'(beat_cnt_o), 32'd0);

        // start and stop together while idle: the job starts.
        mode_i = 2'd0; seed_i = 8'h55; gap_i = 4'd0; num_beats_i = 16'd3;
        start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("startstop_valid", 32'(valid_o), 32'd1);
        chk("startstop_data", 32'(data_o), 32'h55);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0; stop_i = 1'b0;
        chk("startstop_busy", 32'(busy_o), 32'd0);
        chk("startstop_done", 32'(done_o), 32'd0);
        chk("startstop_beat_cnt", 32'(beat_cnt_o), 32'd1);

        // Asynchronous reset mid-beat while stalled.
        mode_i = 2'd0; seed_i = 8'h77; gap_i = 4'd0; num_beats_i = 16'd0; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("prereset_valid", 32'(valid_o), 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        run_job(2'd0, 8'h09, 4'd1, 16'd5, 80, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_source.md
Name: stream_source

Overview:
- Parametrised successor to the fixed-delay 8-bit source.
- Generates a programmable valid/ready data stream for block-level benches and on-chip loopback checks.
- Supports configurable data width, inter-beat gap, job length, packet framing (last_o) and four data modes.
- Sits upstream of any sink that uses the codebase valid/ready convention.

Parameters:
- DATA_W, 8, width of data_o and seed_i.
- GAP_W, 4, width of gap_i; gap range 0..2^GAP_W-1 idle cycles.
- CNT_W, 16, width of num_beats_i and beat_cnt_o.
- PKT_LEN, 16, beats per packet for last_o framing; must be >= 1.
- LFSR_TAPS, 8'hB8, feedback mask for LFSR mode; DATA_W bits wide.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start a job; sampled only in IDLE.
- stop_i  in  1  abort the current job gracefully.
- mode_i  in  2  0 increment, 1 LFSR, 2 constant, 3 decrement.
- seed_i  in  DATA_W  first data value.
- gap_i  in  GAP_W  idle cycles between beats.
- num_beats_i  in  CNT_W  beats per job; 0 = run until stop_i.
- ready_i  in  1  sink ready.
- valid_o  out  1  data_o valid.
- data_o  out  DATA_W  stream data.
- last_o  out  1  final beat of packet or job.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse on normal job completion.
- beat_cnt_o  out  CNT_W  accepted beats in the current or last job.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - state IDLE.
  - valid_o, data_o, last_o, busy_o, done_o and beat_cnt_o all 0.
  - Internal gap and packet counters 0.
- States:
  - IDLE: start_i=1 latches mode_i, gap_i and num_beats_i, loads data_o<=seed_i and clears beat_cnt_o and the packet counter. Goes to SEND if gap_i=0, else GAP.
  - GAP: counts the latched gap cycles with valid_o=0, then SEND.
  - SEND: valid_o=1.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- Latency: start_i in cycle t gives first valid_o=1 in cycle t+1+gap. With gap=0, an accepted beat is followed by valid_o=1 in the next cycle, for full throughput.
- Handshake (transfer = valid_o & ready_i on a rising edge):
  - Once valid_o is high, data_o and last_o hold stable until transfer.
  - valid_o never drops without a transfer, except on reset.
- On transfer:
  - beat_cnt_o+1.
  - Packet counter +1, wrapping at PKT_LEN.
  - data_o advances per mode.
  - If final job beat: DONE. Else if gap>0: GAP. Else stay in SEND.
- Data modes:
  - Increment: +1 mod 2^DATA_W; 0xFF -> 0x00 for DATA_W=8.
  - Decrement: -1 mod 2^DATA_W.
  - Constant: data_o holds seed.
  - LFSR: next = {data[DATA_W-2:0], ^(data & LFSR_TAPS)}. A zero seed in LFSR mode is replaced by 1.
- last_o is 1 during the beat where either condition holds:
  - packet counter = PKT_LEN-1.
  - beat_cnt_o = num_beats-1, with num_beats != 0.
- stop_i:
  - In GAP: go to IDLE next cycle.
  - In SEND: complete the pending beat, then go to IDLE.
  - Leaving on stop never asserts done_o. beat_cnt_o holds.
- start_i while busy_o=1 is ignored. Config inputs are ignored after the latch.
- stop_i and start_i together in IDLE: start wins. stop_i is then applied from the next cycle.
- Infinite mode (num_beats=0): beat_cnt_o wraps at 2^CNT_W. The job ends only via stop_i.
- beat_cnt_o holds its value after DONE or stop, until the next start.

Test Plan:
- Reset mid-SEND with valid_o=1 and ready_i=0 -> same-edge async clear: all outputs 0, state IDLE; a new start then works normally.
- Increment, seed=1, num_beats=256, gap=0, ready_i=1 -> data 1..255,0 on consecutive cycles. last_o on every 16th beat and on beat 256. done_o pulses once and beat_cnt_o=256.
- Increment, seed=0, gap=4, num_beats=8, ready_i=1 -> valid_o pulses one cycle in every five; first valid_o in cycle t+5; data 0..7.
- Backpressure: ready_i toggles 1,0,0,1 pseudo-randomly -> data_o and last_o stable while stalled. No beat lost or duplicated; scoreboard matches the increment reference.
- LFSR, seed=0x01, DATA_W=8, taps 0xB8 -> data 01,02,04,08,11,23; a zero value never appears. Seed=0 behaves as seed=1.
- stop_i asserted in SEND with ready_i=0 for 3 cycles, then ready_i=1 -> beat transferred, IDLE next cycle, done_o stays 0, beat_cnt_o includes that beat.
